rv32_mod_regfile_sb: RTL and testbench
======================================

# rv32_mod_regfile_sb

Parametrised multi-port integer register file with a built-in scoreboard and a hardware clear sequence after reset. It sits between decode/issue and writeback of the rv32 core. It serves N_READ operand reads and N_WRITE writeback ports per cycle, with optional same-cycle write-to-read bypass. Per-register busy bits let long-latency units (divider, loads) reserve a destination and stall dependent issue.

## Interface
- XLEN, 32: register width.
- NREGS, 32: architectural registers (16 for RV32E); AW = $clog2(NREGS).
- N_READ, 2: read ports.
- N_WRITE, 2: write ports.
- INITIAL_SP, 32'h7FFFFFF0: value loaded into x2 by the clear sequence.
- INITIAL_GP, 32'h80000000: value loaded into x3 by the clear sequence.
- ASYNC_READ, 1: 1 = combinational read, 0 = registered read.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- init_done  out  1  high once clear sequence completes.
- read_index  in  [N_READ][AW]  read addresses.
- read_data  out  [N_READ][XLEN]  read data.
- read_busy  out  [N_READ]  addressed register has a pending reservation.
- write_enable  in  [N_WRITE]  write strobe.
- write_index  in  [N_WRITE][AW]  write address.
- write_data  in  [N_WRITE][XLEN]  write data.
- reserve_valid  in  1  request to mark reserve_index busy.
- reserve_index  in  AW  destination to reserve.
- reserve_ready  out  1  reservation accepted this cycle when valid.

## Operation
- FSM states CLEAR and READY. Reset asserted: state=CLEAR, clear counter=1, all busy bits=0, init_done=0, registered read_data=0.
- CLEAR: each cycle writes reg[cnt] with 0, INITIAL_SP for x2, or INITIAL_GP for x3, then increments cnt. After writing cnt==NREGS-1 → READY. All write ports ignored, reserve_ready=0, read_data=0, read_busy=0.
- READY: init_done=1. It stays in READY until reset.
- x0: never written, never busy, always reads 0.
- Write conflicts: several ports write the same index in one cycle → highest-numbered port wins, for both the stored value and bypass.
- Bypass (BYPASS=1): a read of an index written this cycle returns that write_data, and read_busy for it is 0. BYPASS=0: the read returns the old value and the old busy bit.
- Scoreboard: busy[i] is set on reserve_valid && reserve_ready && reserve_index==i, i≠0. It is cleared by any accepted write to i.
- Same-cycle set and clear on one index: set wins.
- reserve_ready = READY && (reserve_index==0 || !busy[reserve_index]). A reservation of an already-busy register is stalled (WAW). Reserving x0 is accepted but has no effect.

## Timing
- ASYNC_READ=1: read_data and read_busy are combinational from read_index in the same cycle.
- ASYNC_READ=0: read_data is registered and valid one cycle after read_index. Bypass compares against the writes in the sampling cycle. read_busy stays combinational.
- Writes land on the rising edge and are visible to non-bypassed reads the next cycle.
- Busy updates are visible next cycle.
- Clear sequence takes NREGS-1 cycles after reset deassertion. init_done rises on the cycle after the last clear write.
- Reset mid-operation aborts any state immediately and restarts CLEAR from cnt=1. Pending reservations are lost.

## Structure
- Package rv32_regfile_pkg:
  - state enum (RF_CLEAR, RF_READY);
  - x0/x2/x3 index constants;
  - a function returning the highest-priority write-hit data for an index.
- Sub-module rv32_mod_regfile_scoreboard holds the NREGS busy bits, set/clear logic, reserve_ready and read_busy lookups.
- Storage array, bypass muxes and the clear FSM live in the top module.

## Test plan
- Reset, then release: init_done low for 31 cycles, then high. Reads then give x1=0, x2=32'h7FFFFFF0, x3=32'h80000000, x31=0.
- Ports 0 and 1 both write x5 (0xAAAA, 0x5555) in one cycle: same-cycle bypassed read returns 0x5555, and the next cycle x5=0x5555. A write of 0x1234 to x0 reads back 0.
- Reserve x7: next cycle read_busy=1. A second reserve of x7 sees reserve_ready=0. A write to x7 of 0x77 gives bypassed read 0x77 with busy=0 in the same cycle, and busy=0 afterwards.
- In one cycle a write to x9 (x9 not busy) plus reserve x9: data stored and x9 busy next cycle (set wins).
- ASYNC_READ=0, BYPASS=0: a write of x4=0x10 with a simultaneous read of x4 returns the old value one cycle later, and 0x10 on the following read.
- Reset asserted mid-CLEAR and again with x6 busy: busy cleared immediately, init_done=0, and the sequence restarts with full 31-cycle latency.

Source files
------------

// File: rtl/rv32_mod_regfile_sb_pkg.sv
// Shared types, register-index constants and the write-port priority helper
// for the rv32 integer register file with scoreboard.
package rv32_regfile_pkg;

    // Clear sequence runs after reset, then the file serves traffic until the next reset.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Architectural registers with special treatment.
    localparam int RF_X0 = 0;   // hard-wired zero
    localparam int RF_X2 = 2;   // sp, preset by the clear sequence
    localparam int RF_X3 = 3;   // gp, preset by the clear sequence

    // Widest port set the priority helper handles. Callers zero-pad narrower
    // configurations; unused write slots must carry en=0.
    localparam int RF_MAX_XLEN  = 32;
    localparam int RF_MAX_AW    = 5;
    localparam int RF_MAX_WRITE = 4;

    // Returns the data of the highest-numbered enabled write port addressing
    // 'addr' this cycle; 'hit' reports whether any port matched.
    function automatic logic [RF_MAX_XLEN-1:0] rf_write_hit(
        input  logic [RF_MAX_WRITE-1:0]                  en,
        input  logic [RF_MAX_WRITE-1:0][RF_MAX_AW-1:0]   idx,
        input  logic [RF_MAX_WRITE-1:0][RF_MAX_XLEN-1:0] data,
        input  logic [RF_MAX_AW-1:0]                     addr,
        output logic                                     hit
    );
        logic [RF_MAX_XLEN-1:0] res;
        res = '0;
        hit = 1'b0;
        // Later ports overwrite earlier matches, so the highest port wins.
        for (int p = 0; p < RF_MAX_WRITE; p++) begin
            if (en[p] && (idx[p] == addr)) begin
                hit = 1'b1;
                res = data[p];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rv32_mod_regfile_sb_if.sv
// Issue/writeback bus of the register file: operand reads, writeback ports,
// destination reservation and the init handshake.
interface rv32_mod_regfile_sb_if #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int N_READ  = 2,
    parameter int N_WRITE = 2
);
    import rv32_regfile_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic                              init_done;
    logic [N_READ-1:0][AW-1:0]         read_index;
    logic [N_READ-1:0][XLEN-1:0]       read_data;
    logic [N_READ-1:0]                 read_busy;
    logic [N_WRITE-1:0]                write_enable;
    logic [N_WRITE-1:0][AW-1:0]        write_index;
    logic [N_WRITE-1:0][XLEN-1:0]      write_data;
    logic                              reserve_valid;
    logic [AW-1:0]                     reserve_index;
    logic                              reserve_ready;

    // Core side: issues reads, writebacks and reservations.
    modport master (
        output read_index, write_enable, write_index, write_data,
               reserve_valid, reserve_index,
        input  init_done, read_data, read_busy, reserve_ready
    );

    // Register file side.
    modport slave (
        input  read_index, write_enable, write_index, write_data,
               reserve_valid, reserve_index,
        output init_done, read_data, read_busy, reserve_ready
    );
endinterface

// File: rtl/rv32_mod_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set by accepted
// reservations and cleared by writebacks. x0 is never busy.
module rv32_mod_regfile_scoreboard
    import rv32_regfile_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int N_READ  = 2,
    parameter int N_WRITE = 2,
    parameter int AW      = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ready_i,
    input  logic                        reserve_valid_i,
    input  logic [AW-1:0]               reserve_index_i,
    output logic                        reserve_ready_o,
    input  logic [N_WRITE-1:0]          clr_en_i,
    input  logic [N_WRITE-1:0][AW-1:0]  clr_index_i,
    input  logic [N_READ-1:0][AW-1:0]   rd_index_i,
    input  logic [N_READ-1:0]           rd_fwd_i,
    output logic [N_READ-1:0]           rd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rsv_fire;

    // A reservation on a busy register is held off (WAW); x0 is always accepted.
    assign reserve_ready_o = ready_i &&
                             ((reserve_index_i == AW'(RF_X0)) || !busy_q[reserve_index_i]);
    assign rsv_fire        = reserve_valid_i && reserve_ready_o;

    // Next busy state: writebacks clear first so a same-cycle reservation wins.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < N_WRITE; p++) begin
            if (clr_en_i[p]) begin
                busy_d[clr_index_i[p]] = 1'b0;
            end
        end
        if (rsv_fire && (reserve_index_i != AW'(RF_X0))) begin
            busy_d[reserve_index_i] = 1'b1;
        end
        busy_d[RF_X0] = 1'b0;
    end

    // Busy bits are control state and drop immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Per read port busy lookup; a forwarded write satisfies the dependency.
    always_comb begin
        rd_busy_o = '0;
        for (int r = 0; r < N_READ; r++) begin
            rd_busy_o[r] = ready_i && busy_q[rd_index_i[r]] && !rd_fwd_i[r];
        end
    end

endmodule

// File: rtl/rv32_mod_regfile_sb.sv
// rv32 integer register file: N_READ operand reads, N_WRITE writebacks,
// optional write-to-read bypass, busy scoreboard and a post-reset clear
// sequence that zeroes the file and presets sp/gp.
module rv32_mod_regfile_sb
    import rv32_regfile_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               NREGS      = 32,
    parameter int               N_READ     = 2,
    parameter int               N_WRITE    = 2,
    parameter logic [XLEN-1:0]  INITIAL_SP = 32'h7FFF_FFF0,
    parameter logic [XLEN-1:0]  INITIAL_GP = 32'h8000_0000,
    parameter int               ASYNC_READ = 1,
    parameter int               BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    rv32_mod_regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_e                    state_q;
    logic [AW-1:0]                cnt_q;
    logic                         init_done_q;
    logic                         ready;

    logic [XLEN-1:0]              regs_q [NREGS];
    logic [XLEN-1:0]              clr_val;

    logic [N_WRITE-1:0]           wr_en_eff;
    logic [RF_MAX_WRITE-1:0]                  wr_en_pad;
    logic [RF_MAX_WRITE-1:0][RF_MAX_AW-1:0]   wr_idx_pad;
    logic [RF_MAX_WRITE-1:0][RF_MAX_XLEN-1:0] wr_data_pad;

    logic [N_READ-1:0]            rd_fwd;
    logic [N_READ-1:0][XLEN-1:0]  rd_comb;

    logic                         sb_reserve_ready;
    logic [N_READ-1:0]            sb_rd_busy;

    assign ready = (state_q == RF_READY);

    // Clear FSM: walks x1..x(NREGS-1) once after reset, then parks in READY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RF_CLEAR;
            cnt_q       <= AW'(1);
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= RF_READY;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                RF_READY: begin
                    state_q <= RF_READY;
                end
                default: begin
                    state_q <= RF_CLEAR;
                end
            endcase
        end
    end

    // Value written by the clear sequence at the current counter position.
    always_comb begin
        clr_val = '0;
        if (cnt_q == AW'(RF_X2)) begin
            clr_val = INITIAL_SP;
        end else if (cnt_q == AW'(RF_X3)) begin
            clr_val = INITIAL_GP;
        end
    end

    // Writebacks count only in READY and never for x0.
    always_comb begin
        wr_en_eff = '0;
        for (int p = 0; p < N_WRITE; p++) begin
            wr_en_eff[p] = ready && bus.write_enable[p] &&
                           (bus.write_index[p] != AW'(RF_X0));
        end
    end

    // Storage: clear writes during CLEAR, writebacks in READY. Later ports
    // are assigned last, so the highest-numbered port owns a shared index.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            regs_q[cnt_q] <= clr_val;
        end else begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (wr_en_eff[p]) begin
                    regs_q[bus.write_index[p]] <= bus.write_data[p];
                end
            end
        end
    end

    // Widen the write ports to the shared priority helper's fixed shape.
    always_comb begin
        wr_en_pad   = '0;
        wr_idx_pad  = '0;
        wr_data_pad = '0;
        for (int p = 0; p < N_WRITE; p++) begin
            wr_en_pad[p]   = wr_en_eff[p];
            wr_idx_pad[p]  = RF_MAX_AW'(bus.write_index[p]);
            wr_data_pad[p] = RF_MAX_XLEN'(bus.write_data[p]);
        end
    end

    // Read mux: x0 reads zero, a same-cycle write is forwarded when bypass is on,
    // and everything reads zero until the clear sequence has finished.
    always_comb begin : p_read_mux
        logic                   hit;
        logic [RF_MAX_XLEN-1:0] fdata;
        hit     = 1'b0;
        fdata   = '0;
        rd_fwd  = '0;
        rd_comb = '0;
        for (int r = 0; r < N_READ; r++) begin
            fdata     = rf_write_hit(wr_en_pad, wr_idx_pad, wr_data_pad,
                                     RF_MAX_AW'(bus.read_index[r]), hit);
            rd_fwd[r] = (BYPASS != 0) && hit;
            if (!ready || (bus.read_index[r] == AW'(RF_X0))) begin
                rd_comb[r] = '0;
            end else if (rd_fwd[r]) begin
                rd_comb[r] = XLEN'(fdata);
            end else begin
                rd_comb[r] = regs_q[bus.read_index[r]];
            end
        end
    end

    generate
        if (ASYNC_READ != 0) begin : g_async_read
            assign bus.read_data = rd_comb;
        end else begin : g_sync_read
            logic [N_READ-1:0][XLEN-1:0] rd_data_q;
            // Registered read port: data appears one cycle after the index.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_comb;
                end
            end
            assign bus.read_data = rd_data_q;
        end
    endgenerate

    rv32_mod_regfile_scoreboard #(
        .NREGS   (NREGS),
        .N_READ  (N_READ),
        .N_WRITE (N_WRITE),
        .AW      (AW)
    ) u_scoreboard (
        .clk             (clk),
        .reset           (reset),
        .ready_i         (ready),
        .reserve_valid_i (bus.reserve_valid),
        .reserve_index_i (bus.reserve_index),
        .reserve_ready_o (sb_reserve_ready),
        .clr_en_i        (wr_en_eff),
        .clr_index_i     (bus.write_index),
        .rd_index_i      (bus.read_index),
        .rd_fwd_i        (rd_fwd),
        .rd_busy_o       (sb_rd_busy)
    );

    assign bus.reserve_ready = sb_reserve_ready;
    assign bus.read_busy     = sb_rd_busy;
    assign bus.init_done     = init_done_q;

endmodule

// File: tb/tb_rv32_mod_regfile_sb.sv
// Bench for rv32_mod_regfile_sb: a default instance (combinational read,
// bypass on) and a registered-read, no-bypass instance share one stimulus.
module tb_rv32_mod_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  localparam int K_DATA_A = 0;
  localparam int K_BUSY_A = 1;
  localparam int K_RDY_A  = 2;
  localparam int K_INIT_A = 3;
  localparam int K_DATA_S = 4;
  localparam int K_BUSY_S = 5;
  localparam int K_RDY_S  = 6;
  localparam int K_INIT_S = 7;

  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [NR-1:0][AW-1:0]   rd_idx;
  logic [NW-1:0]           we;
  logic [NW-1:0][AW-1:0]   wi;
  logic [NW-1:0][XLEN-1:0] wd;
  logic                    rv;
  logic [AW-1:0]           ri;

  rv32_mod_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .N_READ(NR), .N_WRITE(NW)) bus_a ();
  rv32_mod_regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .N_READ(NR), .N_WRITE(NW)) bus_s ();

  assign bus_a.read_index    = rd_idx;
  assign bus_a.write_enable  = we;
  assign bus_a.write_index   = wi;
  assign bus_a.write_data    = wd;
  assign bus_a.reserve_valid = rv;
  assign bus_a.reserve_index = ri;
  assign bus_s.read_index    = rd_idx;
  assign bus_s.write_enable  = we;
  assign bus_s.write_index   = wi;
  assign bus_s.write_data    = wd;
  assign bus_s.reserve_valid = rv;
  assign bus_s.reserve_index = ri;

  rv32_mod_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .N_READ(NR), .N_WRITE(NW),
    .INITIAL_SP(32'h7FFF_FFF0), .INITIAL_GP(32'h8000_0000),
    .ASYNC_READ(1), .BYPASS(1)
  ) u_dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_a)
  );

  rv32_mod_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .N_READ(NR), .N_WRITE(NW),
    .INITIAL_SP(32'h7FFF_FFF0), .INITIAL_GP(32'h8000_0000),
    .ASYNC_READ(0), .BYPASS(0)
  ) u_dut_s (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind, input int port);
    case (kind)
      K_DATA_A: actual = bus_a.read_data[port];
      K_BUSY_A: actual = 32'(bus_a.read_busy[port]);
      K_RDY_A:  actual = 32'(bus_a.reserve_ready);
      K_INIT_A: actual = 32'(bus_a.init_done);
      K_DATA_S: actual = bus_s.read_data[port];
      K_BUSY_S: actual = 32'(bus_s.read_busy[port]);
      K_RDY_S:  actual = 32'(bus_s.reserve_ready);
      K_INIT_S: actual = 32'(bus_s.init_done);
      default:  actual = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations due in this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        logic [31:0] act;
        act = actual(sb_q[i].kind, sb_q[i].port);
        checks++;
        if (act !== sb_q[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h",
                   sb_q[i].name, cyc, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int c, input int k, input int p,
                           input logic [31:0] e, input string n);
    sb_q.push_back('{cyc: c, kind: k, port: p, exp: e, name: n});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_idx = '0;
    we     = '0;
    wi     = '0;
    wd     = '0;
    rv     = 1'b0;
    ri     = '0;
  endtask

  task automatic expect_init(input int r);
    expect_at(r + 30, K_INIT_A, 0, 32'd0, "init_low_last_clear_a");
    expect_at(r + 31, K_INIT_A, 0, 32'd1, "init_high_a");
    expect_at(r + 30, K_INIT_S, 0, 32'd0, "init_low_last_clear_s");
    expect_at(r + 31, K_INIT_S, 0, 32'd1, "init_high_s");
  endtask

  initial begin
    int r;
    idle();
    rst_n = 1'b0;
    tick();
    tick();

    // Held in reset: outputs quiet, reservations refused.
    rv = 1'b1; ri = 5'd7; rd_idx[0] = 5'd2;
    expect_at(cyc, K_INIT_A, 0, 32'd0, "init_in_reset_a");
    expect_at(cyc, K_INIT_S, 0, 32'd0, "init_in_reset_s");
    expect_at(cyc, K_RDY_A, 0, 32'd0, "rdy_in_reset");
    expect_at(cyc, K_DATA_A, 0, 32'd0, "rd_in_reset");
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "busy_in_reset");
    tick();
    idle();

    // Release, then abort the clear sequence part way through.
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    expect_at(cyc, K_INIT_A, 0, 32'd0, "init_abort_clear");
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
    expect_init(r);
    repeat (31) tick();

    checks++;
    if (bus_a.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_direct_a cyc=%0d got=%b", cyc, bus_a.init_done);
    end
    checks++;
    if (bus_s.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_direct_s cyc=%0d got=%b", cyc, bus_s.init_done);
    end

    // Clear results.
    idle(); rd_idx[0] = 5'd1; rd_idx[1] = 5'd2;
    expect_at(cyc, K_DATA_A, 0, 32'd0, "x1_a");
    expect_at(cyc, K_DATA_A, 1, 32'h7FFF_FFF0, "x2_a");
    expect_at(cyc + 1, K_DATA_S, 0, 32'd0, "x1_s");
    expect_at(cyc + 1, K_DATA_S, 1, 32'h7FFF_FFF0, "x2_s");
    tick();
    idle(); rd_idx[0] = 5'd3; rd_idx[1] = 5'd31;
    expect_at(cyc, K_DATA_A, 0, 32'h8000_0000, "x3_a");
    expect_at(cyc, K_DATA_A, 1, 32'd0, "x31_a");
    expect_at(cyc + 1, K_DATA_S, 0, 32'h8000_0000, "x3_s");
    expect_at(cyc + 1, K_DATA_S, 1, 32'd0, "x31_s");
    tick();

    // Two ports write x5; port 1 wins.
    idle(); we = 2'b11;
    wi[0] = 5'd5; wd[0] = 32'h0000_AAAA;
    wi[1] = 5'd5; wd[1] = 32'h0000_5555;
    rd_idx[0] = 5'd5;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_5555, "bypass_prio_x5");
    expect_at(cyc + 1, K_DATA_S, 0, 32'd0, "nobypass_old_x5");
    tick();

    // x5 stored; write to x0 neither forwarded nor stored.
    idle(); we[0] = 1'b1; wi[0] = 5'd0; wd[0] = 32'h0000_1234;
    rd_idx[0] = 5'd5; rd_idx[1] = 5'd0;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_5555, "x5_stored_a");
    expect_at(cyc, K_DATA_A, 1, 32'd0, "x0_write_bypass");
    expect_at(cyc + 1, K_DATA_S, 0, 32'h0000_5555, "x5_stored_s");
    expect_at(cyc + 1, K_DATA_S, 1, 32'd0, "x0_write_s");
    tick();

    // Reserve x7.
    idle(); rd_idx[0] = 5'd0; rd_idx[1] = 5'd7; rv = 1'b1; ri = 5'd7;
    expect_at(cyc, K_DATA_A, 0, 32'd0, "x0_read_after_write");
    expect_at(cyc, K_RDY_A, 0, 32'd1, "rsv_x7_a");
    expect_at(cyc, K_RDY_S, 0, 32'd1, "rsv_x7_s");
    expect_at(cyc, K_BUSY_A, 1, 32'd0, "x7_busy_before");
    tick();

    // Second reservation of x7 stalls (WAW).
    idle(); rv = 1'b1; ri = 5'd7; rd_idx[0] = 5'd7;
    expect_at(cyc, K_RDY_A, 0, 32'd0, "rsv_waw_a");
    expect_at(cyc, K_RDY_S, 0, 32'd0, "rsv_waw_s");
    expect_at(cyc, K_BUSY_A, 0, 32'd1, "x7_busy_a");
    expect_at(cyc, K_BUSY_S, 0, 32'd1, "x7_busy_s");
    tick();

    // Writeback to x7 clears the reservation.
    idle(); we[0] = 1'b1; wi[0] = 5'd7; wd[0] = 32'h0000_0077; rd_idx[0] = 5'd7;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_0077, "x7_bypass_data");
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "x7_bypass_busy");
    expect_at(cyc, K_BUSY_S, 0, 32'd1, "x7_nobypass_busy");
    expect_at(cyc + 1, K_DATA_S, 0, 32'd0, "x7_nobypass_data");
    tick();
    idle(); rd_idx[0] = 5'd7;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_0077, "x7_stored_a");
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "x7_busy_cleared_a");
    expect_at(cyc, K_BUSY_S, 0, 32'd0, "x7_busy_cleared_s");
    expect_at(cyc + 1, K_DATA_S, 0, 32'h0000_0077, "x7_stored_s");
    tick();

    // Write and reserve x9 together: data lands and set wins.
    idle(); we[1] = 1'b1; wi[1] = 5'd9; wd[1] = 32'h0000_0099;
    rv = 1'b1; ri = 5'd9; rd_idx[0] = 5'd9;
    expect_at(cyc, K_RDY_A, 0, 32'd1, "rsv_x9");
    expect_at(cyc, K_DATA_A, 0, 32'h0000_0099, "x9_bypass");
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "x9_bypass_busy");
    tick();
    idle(); rd_idx[0] = 5'd9;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_0099, "x9_stored_a");
    expect_at(cyc, K_BUSY_A, 0, 32'd1, "x9_set_wins_a");
    expect_at(cyc, K_BUSY_S, 0, 32'd1, "x9_set_wins_s");
    expect_at(cyc + 1, K_DATA_S, 0, 32'h0000_0099, "x9_stored_s");
    tick();

    // Registered, unbypassed read of x4 during its write.
    idle(); we[0] = 1'b1; wi[0] = 5'd4; wd[0] = 32'h0000_0010; rd_idx[0] = 5'd4;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_0010, "x4_bypass_a");
    expect_at(cyc + 1, K_DATA_S, 0, 32'd0, "x4_old_s");
    tick();
    idle(); rd_idx[0] = 5'd4;
    expect_at(cyc, K_DATA_A, 0, 32'h0000_0010, "x4_stored_a");
    expect_at(cyc + 1, K_DATA_S, 0, 32'h0000_0010, "x4_new_s");
    tick();

    // Reserving x0 is accepted and leaves it idle.
    idle(); rv = 1'b1; ri = 5'd0;
    expect_at(cyc, K_RDY_A, 0, 32'd1, "rsv_x0");
    tick();
    idle(); rd_idx[0] = 5'd0;
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "x0_never_busy");
    expect_at(cyc, K_DATA_A, 0, 32'd0, "x0_reads_zero");
    tick();

    // Reserve x6, then reset while it is pending.
    idle(); rv = 1'b1; ri = 5'd6;
    expect_at(cyc, K_RDY_A, 0, 32'd1, "rsv_x6");
    tick();
    idle(); rd_idx[0] = 5'd6;
    expect_at(cyc, K_BUSY_A, 0, 32'd1, "x6_busy_a");
    expect_at(cyc, K_BUSY_S, 0, 32'd1, "x6_busy_s");
    tick();
    idle(); rd_idx[0] = 5'd6;
    rst_n = 1'b0;
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "x6_busy_reset");
    expect_at(cyc, K_INIT_A, 0, 32'd0, "init_reset_a");
    expect_at(cyc, K_INIT_S, 0, 32'd0, "init_reset_s");
    tick();
    tick();
    rst_n = 1'b1;
    r = cyc;
    expect_init(r);
    repeat (31) tick();

    checks++;
    if (bus_a.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_direct2_a cyc=%0d got=%b", cyc, bus_a.init_done);
    end
    checks++;
    if (bus_s.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_direct2_s cyc=%0d got=%b", cyc, bus_s.init_done);
    end

    // Reservation lost; earlier data wiped by the new clear pass.
    idle(); rd_idx[0] = 5'd6; rd_idx[1] = 5'd5;
    expect_at(cyc, K_BUSY_A, 0, 32'd0, "x6_busy_lost_a");
    expect_at(cyc, K_BUSY_S, 0, 32'd0, "x6_busy_lost_s");
    expect_at(cyc, K_DATA_A, 1, 32'd0, "x5_recleared_a");
    expect_at(cyc + 1, K_DATA_S, 1, 32'd0, "x5_recleared_s");
    tick();
    idle(); rd_idx[0] = 5'd2;
    expect_at(cyc, K_DATA_A, 0, 32'h7FFF_FFF0, "x2_after_reset_a");
    tick();
    tick();
    tick();

    // Anything still queued was never sampled.
    while (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never_sampled due_cyc=%0d want=%h",
               sb_q[0].name, sb_q[0].cyc, sb_q[0].exp);
      sb_q.delete(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
